// File: rtl/sigcapture_pkg.sv
// Shared types for the trigger-driven sample capture buffer.
package sigcapture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DONE
  } sigcap_state_t;

  function automatic logic is_busy(input sigcap_state_t s);
    return (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read cleared by reset.
module capture_ram #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** A_WIDTH;

  logic [D_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sigcapture.sv
// Oscilloscope-style capture: arms on a pulse, triggers on a rising level crossing,
// keeps PRE_TRIG samples of history and fills the rest of a DEPTH-sample window.
module sigcapture
  import sigcapture_pkg::*;
#(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 8,
  parameter int PRE_TRIG = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic               arm,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] PRE      = A_WIDTH'(PRE_TRIG);
  localparam logic [A_WIDTH-1:0] POST_LEN = A_WIDTH'(DEPTH - PRE_TRIG - 1);
  localparam logic [A_WIDTH-1:0] ONE      = A_WIDTH'(1);

  if ((PRE_TRIG < 1) || (PRE_TRIG > DEPTH - 2)) begin : g_bad_pre_trig
    $error("sigcapture: PRE_TRIG must lie in 1..DEPTH-2");
  end

  sigcap_state_t      state, state_next;
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] start_ptr;
  logic [A_WIDTH-1:0] fill;
  logic [A_WIDTH-1:0] post_cnt;
  logic [D_WIDTH-1:0] prev;
  logic               prev_valid;
  logic               sample_armed;
  logic               sample_post;
  logic               trigger;
  logic               last_sample;
  logic               wr_en;
  logic [A_WIDTH-1:0] rd_index;

  // arm wins over en: a sample arriving with arm never touches the buffer
  assign sample_armed = en && !arm && (state == ARMED);
  assign sample_post  = en && !arm && (state == POST);
  assign wr_en        = sample_armed || sample_post;
  assign trigger      = sample_armed && prev_valid && (prev < trig_level) &&
                        (din >= trig_level) && (fill >= PRE);
  assign last_sample  = sample_post && (post_cnt == ONE);
  assign rd_index     = start_ptr + rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = is_busy(state);
    done       = (state == DONE);
    if (arm) begin
      state_next = ARMED;
    end else begin
      case (state)
        ARMED:   if (trigger) state_next = POST;
        POST:    if (last_sample) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      start_ptr  <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (arm) begin
      wr_ptr     <= '0;
      fill       <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (sample_armed) begin
        prev       <= din;
        prev_valid <= 1'b1;
        if (fill != PRE) begin
          fill <= fill + ONE;
        end
      end
      // window start is taken before this edge's increment, so the trigger lands at PRE
      if (trigger) begin
        start_ptr <= wr_ptr - PRE;
        post_cnt  <= POST_LEN;
      end else if (sample_post) begin
        post_cnt <= post_cnt - ONE;
      end
    end
  end

  capture_ram #(
    .D_WIDTH(D_WIDTH),
    .A_WIDTH(A_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(din),
    .rd_addr(rd_index),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_sigcapture.sv
// Directed bench for sigcapture with depth 16 and four samples of pre-trigger history.
module tb_sigcapture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       arm;
  logic [7:0] din;
  logic [7:0] trig_level;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic       arm;
    logic       en;
    logic [7:0] din;
    logic       exp_busy;
    logic       exp_done;
  } step_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } rd_t;

  logic [7:0] want [16];
  logic [7:0] basic_win [16];
  logic [7:0] rearm_win [16];
  step_t      hist_steps [7];
  rd_t        hist_reads [5];

  sigcapture #(
    .D_WIDTH (8),
    .A_WIDTH (4),
    .PRE_TRIG(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .trig_level(trig_level),
    .arm       (arm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle(input logic a, input logic e, input logic [7:0] d);
    arm = a;
    en  = e;
    din = d;
    @(posedge clk);
    #1;
    arm = 1'b0;
    en  = 1'b0;
  endtask

  task automatic check_window(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, i), 32'(rd_data), 32'(want[i]));
    end
  endtask

  initial begin
    basic_win = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0,
                  8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h00, 8'h10, 8'h20, 8'h30};
    rearm_win = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h90, 8'hC0, 8'hC1, 8'hC2,
                  8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA};
    hist_steps = '{
      '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0},
      '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0}
    };
    hist_reads = '{
      '{4'd4,  8'h10},
      '{4'd0,  8'h10},
      '{4'd1,  8'h00},
      '{4'd5,  8'h20},
      '{4'd15, 8'h2A}
    };

    rst = 1'b1; en = 1'b0; arm = 1'b0; din = '0; trig_level = 8'h80; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 8'h00);

    // basic capture over a rising ramp
    cycle(1'b1, 1'b0, 8'h00);
    check("basic_arm_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 20; j++) begin
      cycle(1'b0, 1'b1, 8'(j * 16));
      check($sformatf("basic_done_%0d", j), 32'(done), 32'(j == 19));
      check($sformatf("basic_busy_%0d", j), 32'(busy), 32'(j != 19));
    end
    want = basic_win;
    check_window("basic_rd");

    // asynchronous reset while DONE with nonzero read data
    check("pre_reset_rd", 32'(rd_data), 32'h30);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle_busy", 32'(busy), 32'd0);

    // insufficient history before the first crossing
    trig_level = 8'h08;
    for (int i = 0; i < 7; i++) begin
      cycle(hist_steps[i].arm, hist_steps[i].en, hist_steps[i].din);
      check($sformatf("hist_busy_%0d", i), 32'(busy), 32'(hist_steps[i].exp_busy));
      check($sformatf("hist_done_%0d", i), 32'(done), 32'(hist_steps[i].exp_done));
    end
    for (int k = 0; k < 11; k++) begin
      cycle(1'b0, 1'b1, 8'(8'h20 + k));
      check($sformatf("hist_post_done_%0d", k), 32'(done), 32'(k == 10));
    end
    for (int i = 0; i < 5; i++) begin
      rd_addr = hist_reads[i].addr;
      @(posedge clk);
      #1;
      check($sformatf("hist_rd_%0d", hist_reads[i].addr), 32'(rd_data), 32'(hist_reads[i].data));
    end

    // enable gaps on every other cycle, with junk on din while en is low
    trig_level = 8'h80;
    cycle(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 20; j++) begin
      cycle(1'b0, 1'b1, 8'(j * 16));
      check($sformatf("gap_done_%0d", j), 32'(done), 32'(j == 19));
      if (j != 19) begin
        cycle(1'b0, 1'b0, 8'hEE);
        check($sformatf("gap_idle_done_%0d", j), 32'(done), 32'd0);
      end
    end
    want = basic_win;
    check_window("gap_rd");

    // re-arm during POST, with a sample presented alongside arm
    cycle(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 11; j++) cycle(1'b0, 1'b1, 8'(j * 16));
    check("rearm_in_post_busy", 32'(busy), 32'd1);
    cycle(1'b1, 1'b1, 8'hFF);
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_done", 32'(done), 32'd0);
    for (int j = 1; j <= 4; j++) begin
      cycle(1'b0, 1'b1, 8'(j));
      check($sformatf("rearm_no_trig_%0d", j), 32'(done), 32'd0);
    end
    cycle(1'b0, 1'b1, 8'h90);
    for (int k = 0; k < 11; k++) begin
      cycle(1'b0, 1'b1, 8'(8'hC0 + k));
      check($sformatf("rearm_post_done_%0d", k), 32'(done), 32'(k == 10));
    end
    want = rearm_win;
    check_window("rearm_rd");

    // DONE holds the window against further samples and crossings
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 8'h55);
    check("hold_done", 32'(done), 32'd1);
    check_window("hold_rd");
    cycle(1'b1, 1'b0, 8'h00);
    check("hold_arm_done", 32'(done), 32'd0);
    check("hold_arm_busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
